// File: rtl/qam_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : qam_symbol_scheduler
// Brief    : Hunts a serial stream for a 12-bit sync word, packs payload bits
//            MSB-first into 6-bit symbols and feeds the 64-QAM mapper through
//            a small FIFO. Optional macro: QAM_SCHED_OVF_CNT_EN (ovf_count).
// Revision : 1.0 - initial release
// ============================================================================
module qam_symbol_scheduler #(
  parameter logic [11:0] SYNC_WORD       = 12'b101100111000,
  parameter int unsigned PAYLOAD_SYMBOLS = 512,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       data_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       data_in,
  input  logic       sym_ready,
  output logic [5:0] sym_data,
  output logic       sym_valid,
  output logic       frame_active,
  output logic       frame_done,
  output logic       overflow
`ifdef QAM_SCHED_OVF_CNT_EN
  ,
  output logic [7:0] ovf_count
`endif
);

  localparam int unsigned       C_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned       C_CNT_W    = C_PTR_W + 1;
  localparam logic [11:0]       C_LAST_SYM = 12'(PAYLOAD_SYMBOLS - 1);
  localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(FIFO_DEPTH);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  // Only the 11 most recent bits are stored; the 12th comes straight from data_in.
  logic [10:0]        sr_q, sr_d;
  logic [4:0]         acc_q, acc_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [11:0]        sym_cnt_q, sym_cnt_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
`ifdef QAM_SCHED_OVF_CNT_EN
  logic [7:0]         ovf_cnt_q, ovf_cnt_d;
`endif

  logic [5:0]         mem_q [FIFO_DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0] count_q, count_d;

  logic [11:0]        w_sr_next;
  logic [5:0]         w_push_sym;
  logic               w_push_req;
  logic               w_push_ok;
  logic               w_pop;
  logic               w_not_empty;

  assign w_sr_next   = {sr_q, data_in};
  assign w_push_sym  = {acc_q, data_in};
  assign w_not_empty = (count_q != '0);
  assign w_pop       = w_not_empty & sym_ready;
  // A full FIFO still takes the new symbol when the head leaves on the same edge.
  assign w_push_ok   = w_push_req & ((count_q < C_DEPTH) | w_pop);

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    bit_idx_d  = bit_idx_q;
    sym_cnt_d  = sym_cnt_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    w_push_req = 1'b0;
`ifdef QAM_SCHED_OVF_CNT_EN
    ovf_cnt_d  = ovf_cnt_q;
`endif
    if (enable) begin
      case (state_q)
        HUNT: begin
          sr_d = w_sr_next[10:0];
          if (w_sr_next == SYNC_WORD) begin
            state_d   = PAYLOAD;
            bit_idx_d = 3'd0;
            sym_cnt_d = 12'd0;
            ovf_d     = 1'b0;
`ifdef QAM_SCHED_OVF_CNT_EN
            ovf_cnt_d = 8'd0;
`endif
          end
        end
        PAYLOAD: begin
          acc_d = {acc_q[3:0], data_in};
          if (bit_idx_q == 3'd5) begin
            w_push_req = 1'b1;
            bit_idx_d  = 3'd0;
            sym_cnt_d  = sym_cnt_q + 12'd1;
            if (sym_cnt_q == C_LAST_SYM) begin
              state_d = HUNT;
              sr_d    = 11'd0;
              done_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // Dropped symbols still count toward the frame length.
    if (w_push_req && !w_push_ok) begin
      ovf_d = 1'b1;
`ifdef QAM_SCHED_OVF_CNT_EN
      if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
`endif
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
    if (w_push_ok && !w_pop) begin
      count_d = count_q + C_CNT_W'(1);
    end else if (!w_push_ok && w_pop) begin
      count_d = count_q - C_CNT_W'(1);
    end
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      acc_q     <= '0;
      bit_idx_q <= '0;
      sym_cnt_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef QAM_SCHED_OVF_CNT_EN
      ovf_cnt_q <= '0;
`endif
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      bit_idx_q <= bit_idx_d;
      sym_cnt_q <= sym_cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
`ifdef QAM_SCHED_OVF_CNT_EN
      ovf_cnt_q <= ovf_cnt_d;
`endif
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the output is gated by the (reset) occupancy count.
  always_ff @(posedge data_clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= w_push_sym;
    end
  end

  assign sym_valid    = w_not_empty;
  assign sym_data     = w_not_empty ? mem_q[rd_ptr_q] : 6'd0;
  assign frame_active = (state_q == PAYLOAD);
  assign frame_done   = done_q;
  assign overflow     = ovf_q;
`ifdef QAM_SCHED_OVF_CNT_EN
  assign ovf_count    = ovf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qam_symbol_scheduler.sv
`default_nettype none
// Bench for qam_symbol_scheduler: directed frames with an expected-symbol queue
// checked against every handshake pop.
module tb_qam_symbol_scheduler;

  localparam int unsigned PAYLOAD_SYMBOLS = 6;
  localparam int unsigned FIFO_DEPTH      = 4;

  logic       data_clk  = 1'b0;
  logic       rst_n     = 1'b0;
  logic       enable    = 1'b0;
  logic       data_in   = 1'b0;
  logic       sym_ready = 1'b0;
  logic [5:0] sym_data;
  logic       sym_valid;
  logic       frame_active;
  logic       frame_done;
  logic       overflow;
`ifdef QAM_SCHED_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  int         checks = 0;
  int         errors = 0;
  int         n_pop  = 0;
  int         start  = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;
  logic [5:0] s5;

  always #5 data_clk = ~data_clk;

  qam_symbol_scheduler #(
    .SYNC_WORD       (12'hB38),
    .PAYLOAD_SYMBOLS (PAYLOAD_SYMBOLS),
    .FIFO_DEPTH      (FIFO_DEPTH)
  ) dut (
    .data_clk     (data_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .data_in      (data_in),
    .sym_ready    (sym_ready),
    .sym_data     (sym_data),
    .sym_valid    (sym_valid),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .overflow     (overflow)
`ifdef QAM_SCHED_OVF_CNT_EN
    ,
    .ovf_count    (ovf_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A pop happens at the next rising edge whenever valid&ready is seen here.
  always @(negedge data_clk) begin
    if (rst_n && sym_valid && sym_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_symbol: observed 0x%0h expected none", sym_data);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("sym_data", 32'(sym_data), 32'(mon_exp));
      end
      n_pop++;
    end
  end

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    enable  = 1'b1;
    data_in = b;
    tick();
    enable  = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] w);
    for (int i = 11; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_sync(input string tag);
    logic [11:0] w;
    w = 12'hB38;
    for (int i = 11; i >= 1; i--) send_bit(w[i]);
    check({tag, "_pre_active"}, 32'(frame_active), 32'd0);
    send_bit(w[0]);
    check({tag, "_active"}, 32'(frame_active), 32'd1);
  endtask

  task automatic send_sym(input logic [5:0] s, input bit accepted);
    for (int i = 5; i >= 0; i--) begin
      if (i == 0 && accepted) exp_q.push_back(s);
      send_bit(s[i]);
    end
  endtask

  task automatic drain(input string tag, input int from, input int exp_n);
    sym_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !sym_valid) break;
      tick();
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_delivered"}, 32'(n_pop - from), 32'(exp_n));
    check({tag, "_valid_low"}, 32'(sym_valid), 32'd0);
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_sym_data", 32'(sym_data), 32'd0);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef QAM_SCHED_OVF_CNT_EN
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif
    rst_n     = 1'b1;
    sym_ready = 1'b1;
    repeat (20) tick();
    check("idle_sym_valid", 32'(sym_valid), 32'd0);
    check("idle_frame_active", 32'(frame_active), 32'd0);

    // Basic frame, mapper always ready
    start = n_pop;
    send_sync("basic");
    send_sym(6'h2A, 1'b1);
    send_sym(6'h3F, 1'b1);
    send_sym(6'h00, 1'b1);
    send_sym(6'h13, 1'b1);
    send_sym(6'h15, 1'b1);
    check("basic_done_early", 32'(frame_done), 32'd0);
    check("basic_active_mid", 32'(frame_active), 32'd1);
    send_sym(6'h2C, 1'b1);
    check("basic_done", 32'(frame_done), 32'd1);
    check("basic_active_end", 32'(frame_active), 32'd0);
    tick();
    check("basic_done_pulse", 32'(frame_done), 32'd0);
    drain("basic", start, 6);
    check("basic_overflow", 32'(overflow), 32'd0);

    // False sync then overlapping real sync, followed by back-pressure
    sym_ready = 1'b0;
    start = n_pop;
    send_word(12'hB30);
    check("false_sync", 32'(frame_active), 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_sync("overlap");
    send_sym(6'h01, 1'b1);
    send_sym(6'h22, 1'b1);
    send_sym(6'h3E, 1'b1);
    send_sym(6'h0C, 1'b1);
    check("bp_no_ovf_yet", 32'(overflow), 32'd0);
    check("bp_valid", 32'(sym_valid), 32'd1);
    send_sym(6'h15, 1'b0);
    check("bp_overflow", 32'(overflow), 32'd1);
    send_sym(6'h2A, 1'b0);
    check("bp_done", 32'(frame_done), 32'd1);
`ifdef QAM_SCHED_OVF_CNT_EN
    check("bp_ovf_count", 32'(ovf_count), 32'd2);
`endif
    tick();
    check("bp_head_stable", 32'(sym_data), 32'(exp_q[0]));
    drain("bp", start, 4);
    check("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop on the edge the next symbol completes
    sym_ready = 1'b0;
    start = n_pop;
    send_sync("fullpop");
    check("fullpop_ovf_cleared", 32'(overflow), 32'd0);
    send_sym(6'h11, 1'b1);
    send_sym(6'h22, 1'b1);
    send_sym(6'h33, 1'b1);
    send_sym(6'h04, 1'b1);
    s5 = 6'h3B;
    for (int i = 5; i >= 1; i--) send_bit(s5[i]);
    sym_ready = 1'b1;
    exp_q.push_back(s5);
    send_bit(s5[0]);
    sym_ready = 1'b0;
    check("fullpop_no_ovf", 32'(overflow), 32'd0);
    send_sym(6'h07, 1'b0);
    check("fullpop_still_full_drop", 32'(overflow), 32'd1);
    check("fullpop_done", 32'(frame_done), 32'd1);
    drain("fullpop", start, 5);

    // Mid-frame asynchronous reset with two symbols queued
    sym_ready = 1'b0;
    send_sync("midrst");
    send_sym(6'h0F, 1'b1);
    send_sym(6'h30, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("midrst_queued", 32'(sym_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(sym_valid), 32'd0);
    check("midrst_active", 32'(frame_active), 32'd0);
    check("midrst_data", 32'(sym_data), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("midrst_hunting", 32'(frame_active), 32'd0);
    sym_ready = 1'b1;
    start = n_pop;
    send_sync("rehunt");
    check("rehunt_overflow", 32'(overflow), 32'd0);
    send_sym(6'h3C, 1'b1);
    send_sym(6'h03, 1'b1);
    send_sym(6'h29, 1'b1);
    send_sym(6'h16, 1'b1);
    send_sym(6'h38, 1'b1);
    send_sym(6'h05, 1'b1);
    check("rehunt_done", 32'(frame_done), 32'd1);
    drain("rehunt", start, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/qam_symbol_scheduler.md
# qam_symbol_scheduler

Frame-level scheduler between the serial baseband input and the 64-QAM mapper. It hunts the serial bit stream for a 12-bit sync word, then packs the following payload bits MSB-first into 6-bit symbols. Symbols are queued in a small FIFO and delivered to the mapper over a valid/ready handshake. It reports frame activity, end of frame and dropped symbols. It replaces ad-hoc header/enable sequencing with a buffered, back-pressure-aware symbol source.

## Interface
Parameters:
- SYNC_WORD, 12'b101100111000, frame sync/header pattern.
- PAYLOAD_SYMBOLS, 512, symbols per frame (512 × 6 = 3072 bits); legal range 1..4095.
- FIFO_DEPTH, 4, symbol FIFO depth; power of two, 2..16.

Ports:
- data_clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  bit strobe; data_in is sampled only when enable=1.
- data_in  in  1  serial baseband bit.
- sym_ready  in  1  mapper accepts the head symbol.
- sym_data  out  6  FIFO head symbol; bit 5 is the first-received bit.
- sym_valid  out  1  FIFO not empty.
- frame_active  out  1  high while in PAYLOAD.
- frame_done  out  1  one-cycle pulse on the last payload bit.
- overflow  out  1  sticky; a symbol was dropped in the current frame.

## Operation
- Two states: HUNT (the reset state) and PAYLOAD.
- HUNT, on an enable cycle:
  - sr_next = {sr[10:0], data_in}.
  - If sr_next == SYNC_WORD, go to PAYLOAD. In the same edge: clear bit_idx (0..5), sym_cnt, overflow and, if compiled in, ovf_count.
  - The sync bits themselves are never queued.
- PAYLOAD, on an enable cycle:
  - acc = {acc[4:0], data_in}; bit_idx increments.
  - When bit_idx==5, the symbol {acc[4:0], data_in} is offered to the FIFO, bit_idx wraps to 0 and sym_cnt increments.
  - When sym_cnt==PAYLOAD_SYMBOLS-1 and bit_idx==5: push the final symbol, pulse frame_done, clear sr to 0 and return to HUNT.
- A push is accepted if FIFO count < FIFO_DEPTH, or if a pop happens in the same cycle (sym_valid & sym_ready).
  - Otherwise the symbol is dropped, overflow is set and sym_cnt still advances, so frame length is preserved.
- Pop: sym_valid & sym_ready at an edge removes the head.
- The FIFO output side runs independently of enable and of the state. Symbols of a finished frame keep draining during HUNT and into the next frame.
- enable=0: shift register, accumulator, counters and state hold; FIFO pops still proceed.
- Sync detection in HUNT is bit-by-bit, so overlapping patterns are detected. No sync search happens during PAYLOAD.
- Widths: sym_cnt is 12 bits; FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: sym_data=0, sym_valid=0, frame_active=0, frame_done=0, overflow=0, ovf_count=0. FIFO is empty, state is HUNT, sr/acc/bit_idx/sym_cnt are 0.
- The sync match on edge N gives frame_active=1 after edge N.
- A push on edge N gives sym_valid=1 after edge N, with sym_data valid in the same cycle (latency 1 from the 6th bit's edge).
- Simultaneous push and pop: count is unchanged and the push is accepted even when full. The head advances and the new symbol lands at the tail.
- frame_done is high for exactly the cycle after the final bit's edge; frame_active falls on the same edge.
- sym_data is stable while sym_valid=1 and sym_ready=0.
- rst_n assertion mid-frame: all outputs go to their reset values immediately (asynchronously). FIFO contents are discarded and the block re-hunts after release.

## Configuration
- QAM_SCHED_OVF_CNT_EN defined:
  - Adds output port ovf_count [7:0], the number of dropped symbols in the current frame.
  - Saturates at 255, is cleared on sync detection, resets to 0.
- Not defined: no ovf_count port and no counter logic. overflow behaves identically in both builds.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release with enable=0 → all outputs 0, state HUNT, no symbols for 20 cycles.
- Basic frame (PAYLOAD_SYMBOLS=4, sym_ready=1): send 0xB38, then 24 bits 101010_111111_000000_010011 → sym_data sequence 0x2A, 0x3F, 0x00, 0x13, one sym_valid each. frame_done pulses once after bit 24.
- False and overlapping sync: send 0xB30 then 0x0B38 → no frame start on the first word; frame starts on the completed 0xB38. Payload bits before sync produce no symbols.
- Back-pressure (FIFO_DEPTH=4, PAYLOAD_SYMBOLS=6, sym_ready=0): send a full frame → symbols 1–4 held, symbols 5–6 dropped, overflow=1, ovf_count=2 (macro on). Raise sym_ready → exactly 4 symbols delivered in order.
- Full plus simultaneous pop: FIFO full, sym_ready=1 on the cycle the next symbol completes → push accepted, no overflow, count stays 4.
- Mid-frame reset: assert rst_n after symbol 2 of 4, with 2 symbols queued → sym_valid=0 and frame_active=0 immediately. A new sync after release starts a clean frame with overflow=0.
